fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request, IF/ID pipeline register
// and a one-entry skid buffer that catches a returning word while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        dbg_state
);

  // Handshake: imem_rdata is taken on a rising edge where imem_req && imem_ready;
  // decode consumes IF/ID on a rising edge where valid && !stall.
  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      instr_d      = 32'd0;
      valid_d      = 1'b0;
      skid_instr_d = 32'd0;
      skid_pc_d    = 32'd0;
      state_d      = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_plus4;
              state_d      = S_HOLD;
            end else begin
              instr_d  = imem_rdata;
              pc_out_d = pc_plus4;
              valid_d  = 1'b1;
            end
          end else if (!stall) begin
            instr_d = 32'd0;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_d      = skid_instr_q;
            pc_out_d     = skid_pc_q;
            valid_d      = 1'b1;
            skid_instr_d = 32'd0;
            skid_pc_d    = 32'd0;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
      // Flush bubbles IF/ID even under stall; PC, FSM and skid proceed as usual.
      if (flush) begin
        instr_d  = 32'd0;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      pc_out_q     <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_out_q;
  assign instruction = instr_q;
  assign valid       = valid_q;
  assign dbg_state   = (state_q == S_HOLD);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected {instruction, pc_out} pairs are queued
// at issue time and popped by a monitor whenever decode consumes IF/ID.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc_out(pc_out), .instruction(instruction),
    .valid(valid), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word content is derived from its address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic st, input logic fl, input logic br,
                       input logic [31:0] tgt, input logic rdy);
    stall         = st;
    flush         = fl;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_q.push_back({word(addr), addr + 32'd4});
  endtask

  // Monitor / scoreboard: IF/ID is consumed before an edge with valid && !stall.
  always @(negedge clk) begin
    if (reset && valid && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL consume_unexpected: got instr %h pc %h with empty queue", instruction, pc_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({instruction, pc_out} !== e) begin
          errors++;
          $display("FAIL consume: got instr %h pc %h expected instr %h pc %h",
                   instruction, pc_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);

    // Sequential fetch from reset
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4));
      tick();
      chk("seq_addr", imem_addr, 32'(i * 4 + 4));
      if (i == 0) begin
        chk("seq_valid", {31'd0, valid}, 32'd1);
        chk("seq_pc_out", pc_out, 32'h4);
      end
    end

    // Stall for three cycles while memory keeps answering at PC=0x10
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    push(32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_state", {31'd0, dbg_state}, 32'd1);
      chk("hold_instr", instruction, word(32'hC));
      chk("hold_pc_out", pc_out, 32'h10);
      chk("hold_addr", imem_addr, 32'h14);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    chk("release_instr", instruction, word(32'h10));
    chk("release_pc_out", pc_out, 32'h14);
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h14);

    // Memory not ready: two bubbles, PC unchanged, then resume
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bubble_valid", {31'd0, valid}, 32'd0);
      chk("bubble_instr", instruction, 32'd0);
      chk("bubble_pc_out", pc_out, 32'h14);
      chk("bubble_addr", imem_addr, 32'h14);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    push(32'h14);
    tick();
    chk("resume_addr", imem_addr, 32'h18);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();

    // Branch overrides stall and imem_ready; target alignment forced
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    tick();
    chk("br_addr", imem_addr, 32'h100);
    chk("br_valid", {31'd0, valid}, 32'd0);
    chk("br_instr", instruction, 32'd0);
    chk("br_pc_out", pc_out, 32'h18);
    chk("br_req", {31'd0, imem_req}, 32'd1);

    // Flush drops the accepted word but PC still advances
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    chk("flush_valid", {31'd0, valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h104);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    push(32'h104);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();

    // PC wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    push(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_out", pc_out, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();

    // Reset while in HOLD: skid word must never appear
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    chk("skid_hold_state", {31'd0, dbg_state}, 32'd1);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    tick();
    chk("hrst_valid", {31'd0, valid}, 32'd0);
    chk("hrst_instr", instruction, 32'd0);
    chk("hrst_pc_out", pc_out, 32'd0);
    chk("hrst_req", {31'd0, imem_req}, 32'd1);
    chk("hrst_addr", imem_addr, 32'h0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_valid", {31'd0, valid}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    push(32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
